// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel-rate divider, x/y counters, sync strobes,
// active-region flag and per-frame pulses for the renderer and game logic.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV     = 2,
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_ACT_START = 144,
   parameter int unsigned H_ACT_END   = 784,
   parameter int unsigned V_TOTAL     = 525,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_ACT_START = 35,
   parameter int unsigned V_ACT_END   = 515
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        hor_sync,
   output logic        ver_sync,
   output logic        pix_en,
   output logic        active,
   output logic        frame_start,
   output logic        vblank_tick,
   output logic [15:0] frame_count
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned XY_W  = 10;
   localparam int unsigned FC_W  = 16;

   logic [DIV_W-1:0] r_div_cnt;
   logic [XY_W-1:0]  r_x;
   logic [XY_W-1:0]  r_y;
   logic             r_hor_sync;
   logic             r_ver_sync;
   logic             r_active;
   logic             r_frame_start;
   logic             r_vblank_tick;
   logic [FC_W-1:0]  r_frame_count;

   logic             w_div_last;
   logic             w_pix_en;
   logic             w_x_last;
   logic             w_y_last;
   logic             w_frame_wrap;
   logic [XY_W-1:0]  w_x_nxt;
   logic [XY_W-1:0]  w_y_nxt;

   assign w_div_last   = (r_div_cnt == DIV_W'(CLK_DIV - 1));
   assign w_pix_en     = enable && w_div_last;
   assign w_x_last     = (r_x == XY_W'(H_TOTAL - 1));
   assign w_y_last     = (r_y == XY_W'(V_TOTAL - 1));
   assign w_frame_wrap = w_pix_en && w_x_last && w_y_last;

   // Next raster position; sync/active are derived from it so they never lag x/y
   always_comb begin
      w_x_nxt = r_x;
      w_y_nxt = r_y;
      if (w_pix_en) begin
         if (w_x_last) begin
            w_x_nxt = '0;
            w_y_nxt = w_y_last ? '0 : r_y + XY_W'(1);
         end else begin
            w_x_nxt = r_x + XY_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div_cnt     <= '0;
         r_x           <= '0;
         r_y           <= '0;
         r_hor_sync    <= 1'b0;
         r_ver_sync    <= 1'b0;
         r_active      <= 1'b0;
         r_frame_start <= 1'b0;
         r_vblank_tick <= 1'b0;
         r_frame_count <= '0;
      end else if (enable) begin
         r_div_cnt     <= w_div_last ? '0 : r_div_cnt + DIV_W'(1);
         r_x           <= w_x_nxt;
         r_y           <= w_y_nxt;
         r_hor_sync    <= (w_x_nxt >= XY_W'(H_SYNC));
         r_ver_sync    <= (w_y_nxt >= XY_W'(V_SYNC));
         r_active      <= (w_x_nxt >= XY_W'(H_ACT_START)) && (w_x_nxt < XY_W'(H_ACT_END)) &&
                          (w_y_nxt >= XY_W'(V_ACT_START)) && (w_y_nxt < XY_W'(V_ACT_END));
         r_frame_start <= w_frame_wrap;
         r_vblank_tick <= w_pix_en && w_x_last && (r_y == XY_W'(V_ACT_END - 1));
         if (w_frame_wrap) begin
            r_frame_count <= r_frame_count + FC_W'(1);
         end
      end else begin
         // Frozen: everything holds except the one-clk pulses
         r_frame_start <= 1'b0;
         r_vblank_tick <= 1'b0;
      end
   end

   assign x           = r_x;
   assign y           = r_y;
   assign hor_sync    = r_hor_sync;
   assign ver_sync    = r_ver_sync;
   assign pix_en      = w_pix_en;
   assign active      = r_active;
   assign frame_start = r_frame_start;
   assign vblank_tick = r_vblank_tick;
   assign frame_count = r_frame_count;

endmodule
